bcd_updown_counter: RTL and testbench
=====================================

Name: bcd_updown_counter

Overview:
- Four-digit BCD up/down counter (value3 = MSD … value0 = LSD) that drives the stopwatch/timer display path.
- Consumes increase_en/decrease_en from the direction/enable decode stage. Feeds its value0..value3 back to that stage and forward to the 7-segment scan driver.
- Owns the run/pause/done control state and the preset load.

Parameters:
- UP_LIMIT, 16'h9999, BCD terminal value for count-up; digits packed {value3,value2,value1,value0}.
- DIGIT_MAX, 4'd9, largest legal BCD digit.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- tick  input  1  single-cycle count-enable pulse from the clock divider (e.g. 1 Hz).
- increase_en  input  1  count-up request from the enable decode stage.
- decrease_en  input  1  count-down request from the enable decode stage.
- load  input  1  single-cycle pulse; loads preset digits.
- start_pause  input  1  single-cycle debounced pulse; toggles run/pause.
- preset0..preset3  input  4 each  preset BCD digits (preset3 = MSD).
- value0..value3  output  4 each  registered BCD count (value3 = MSD).
- running  output  1  high in RUN state.
- done  output  1  high in DONE state.

Behaviour:
- Reset (asynchronous, rst_n low):
  - value0..value3 = 0; state = STOP; running = 0; done = 0.
  - Takes effect immediately, including mid-count. Release is ordinary: first update at the first qualifying edge after rst_n rises.
- FSM states: STOP, RUN, PAUSE, DONE. running = (state==RUN); done = (state==DONE); both registered.
- Priority per edge: load > start_pause > tick.
- load:
  - Accepted from any state; next state STOP.
  - Each value_i = preset_i, except a preset digit > DIGIT_MAX is clamped to DIGIT_MAX.
  - Any start_pause or tick in the same cycle is ignored.
- start_pause:
  - STOP -> RUN; RUN -> PAUSE; PAUSE -> RUN; DONE -> DONE (ignored).
  - A tick in the same cycle as start_pause is ignored.
- Counting:
  - Happens only in RUN on an edge where tick=1. The value updates at that edge (1-cycle latency from the tick sample).
  - increase_en=1, decrease_en=0: BCD increment. Digit 9 -> 0 with carry to the next digit.
  - decrease_en=1, increase_en=0: BCD decrement. Digit 0 -> 9 with borrow from the next digit.
  - Both 0, or both 1 (illegal): hold value, stay in RUN.
- Terminal conditions:
  - Count-up: if the pre-increment value equals UP_LIMIT, hold it (no wrap to 0000) and go to DONE. If the increment produces UP_LIMIT, go to DONE on that same edge.
  - Count-down: if the decrement produces 0000, go to DONE on that same edge. 0000 never wraps to 9999.
  - Value 0000 in RUN with both enables low (the upstream stage drops both at zero): hold, no transition.
- PAUSE, STOP and DONE ignore tick. value holds.
- Outputs change only on clk edges or reset; no combinational path from inputs to outputs.

Decomposition:
- Shared package: FSM state encoding (STOP=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3), DIGIT_MAX, and the UP_LIMIT default constant.
- One sub-module: bcd_digit_step, a combinational single-digit step.
  - Inputs: digit, up, down, carry_in.
  - Outputs: next digit, carry_out (on 9->0 going up; on 0->9 going down).
  - Instantiated four times in a ripple chain. Digit 0 has carry_in = tick & RUN & exactly-one-enable.

Test Plan:
- Reset mid-count: running at value 0123, assert rst_n=0 between edges -> outputs 0000, running=0, done=0 immediately. After release, tick is ignored until start_pause.
- Up-count carry: load 0998, start_pause, increase_en=1, three ticks -> 0999, 1000, 1001. running=1 throughout.
- Up terminal: load 9998, run up, two ticks -> 9999 with done=1 on the first tick's edge. Second tick leaves 9999. start_pause while done -> no change.
- Down borrow and terminal: load 0101, run with decrease_en=1 -> 0100, 0099, … 0001, then 0000 with done=1 on that same edge. Further ticks hold 0000.
- Priority and clamp: load with preset {3,12,15,4} while start_pause=1 and tick=1 -> value 3994, state STOP, running=0.
- Pause and illegal enables: run 0050 down, start_pause -> PAUSE. Ticks hold 0050. start_pause resumes. With increase_en=decrease_en=1 -> tick holds 0050 and stays RUN.

Source files
------------

// File: rtl/bcd_updown_counter_pkg.sv
//==============================================================================
// Module  : bcd_updown_counter_pkg
// Brief   : Shared FSM encoding, digit limits and preset clamp for the counter.
// Revision: 1.0
//==============================================================================
`default_nettype none

package bcd_updown_counter_pkg;

    localparam logic [1:0]  C_ST_STOP  = 2'd0;
    localparam logic [1:0]  C_ST_RUN   = 2'd1;
    localparam logic [1:0]  C_ST_PAUSE = 2'd2;
    localparam logic [1:0]  C_ST_DONE  = 2'd3;

    localparam logic [3:0]  C_DIGIT_MAX        = 4'd9;
    localparam logic [15:0] C_UP_LIMIT_DEFAULT = 16'h9999;

    // Out-of-range preset digits saturate to the largest legal digit.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max_d);
        clamp_digit = (d > max_d) ? max_d : d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_step.sv
//==============================================================================
// Module  : bcd_digit_step
// Brief   : Combinational single BCD digit increment/decrement with ripple carry.
// Revision: 1.0
//==============================================================================
`default_nettype none

module bcd_digit_step
    import bcd_updown_counter_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       up,
    input  logic       down,
    input  logic       carry_in,
    output logic [3:0] next_digit,
    output logic       carry_out
);

    always_comb begin
        next_digit = digit;
        carry_out  = 1'b0;
        if (carry_in && up && !down) begin
            if (digit >= C_DIGIT_MAX) begin
                next_digit = 4'd0;
                carry_out  = 1'b1;
            end else begin
                next_digit = digit + 4'd1;
            end
        end else if (carry_in && down && !up) begin
            if (digit == 4'd0) begin
                next_digit = C_DIGIT_MAX;
                carry_out  = 1'b1;
            end else begin
                next_digit = digit - 4'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bcd_updown_counter.sv
//==============================================================================
// Module  : bcd_updown_counter
// Brief   : Four-digit BCD up/down counter with run/pause/done control and preset.
// Revision: 1.0
//==============================================================================
`default_nettype none

module bcd_updown_counter
    import bcd_updown_counter_pkg::*;
#(
    parameter logic [15:0] UP_LIMIT  = C_UP_LIMIT_DEFAULT,
    parameter logic [3:0]  DIGIT_MAX = C_DIGIT_MAX
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       increase_en,
    input  logic       decrease_en,
    input  logic       load,
    input  logic       start_pause,
    input  logic [3:0] preset0,
    input  logic [3:0] preset1,
    input  logic [3:0] preset2,
    input  logic [3:0] preset3,
    output logic [3:0] value0,
    output logic [3:0] value1,
    output logic [3:0] value2,
    output logic [3:0] value3,
    output logic       running,
    output logic       done
);

    logic [1:0]  r_state;
    logic [15:0] r_value;
    logic        r_running;
    logic        r_done;

    logic [1:0]  w_next_state;
    logic [15:0] w_next_value;
    logic [15:0] w_step_value;
    logic [3:0]  w_carry_in;
    logic [3:0]  w_carry_out;
    logic        w_step_en;
    logic        w_hold_terminal;

    assign w_step_en     = tick && (r_state == C_ST_RUN) && (increase_en ^ decrease_en);
    assign w_carry_in[0] = w_step_en;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            if (gi > 0) begin : g_ripple
                assign w_carry_in[gi] = w_carry_out[gi-1];
            end
            bcd_digit_step u_step (
                .digit      (r_value[4*gi +: 4]),
                .up         (increase_en),
                .down       (decrease_en),
                .carry_in   (w_carry_in[gi]),
                .next_digit (w_step_value[4*gi +: 4]),
                .carry_out  (w_carry_out[gi])
            );
        end
    endgenerate

    // A carry out of the MSD means 9999->0000 or 0000->9999; never allow the wrap.
    assign w_hold_terminal = (increase_en && (r_value == UP_LIMIT)) || w_carry_out[3];

    always_comb begin
        w_next_state = r_state;
        w_next_value = r_value;
        if (load) begin
            w_next_state = C_ST_STOP;
            w_next_value = {clamp_digit(preset3, DIGIT_MAX), clamp_digit(preset2, DIGIT_MAX),
                            clamp_digit(preset1, DIGIT_MAX), clamp_digit(preset0, DIGIT_MAX)};
        end else if (start_pause) begin
            case (r_state)
                C_ST_STOP:  w_next_state = C_ST_RUN;
                C_ST_RUN:   w_next_state = C_ST_PAUSE;
                C_ST_PAUSE: w_next_state = C_ST_RUN;
                default:    w_next_state = r_state;
            endcase
        end else if (w_step_en) begin
            if (w_hold_terminal) begin
                w_next_state = C_ST_DONE;
            end else begin
                w_next_value = w_step_value;
                if ((increase_en && (w_step_value == UP_LIMIT)) ||
                    (decrease_en && (w_step_value == 16'h0000))) begin
                    w_next_state = C_ST_DONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= C_ST_STOP;
            r_value   <= 16'h0000;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_value   <= w_next_value;
            r_running <= (w_next_state == C_ST_RUN);
            r_done    <= (w_next_state == C_ST_DONE);
        end
    end

    assign value0  = r_value[3:0];
    assign value1  = r_value[7:4];
    assign value2  = r_value[11:8];
    assign value3  = r_value[15:12];
    assign running = r_running;
    assign done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_bcd_updown_counter.sv
//==============================================================================
// Module  : tb_bcd_updown_counter
// Brief   : Scoreboard bench for the four-digit BCD up/down counter.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_bcd_updown_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick, increase_en, decrease_en, load, start_pause;
    logic [3:0] preset0, preset1, preset2, preset3;
    logic [3:0] value0, value1, value2, value3;
    logic       running, done;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [17:0] exp_q[$];
    string       name_q[$];
    event        ev_check;
    logic [17:0] m_exp;
    string       m_name;
    logic [15:0] dut_val;

    always #5 clk = ~clk;

    bcd_updown_counter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .increase_en (increase_en),
        .decrease_en (decrease_en),
        .load        (load),
        .start_pause (start_pause),
        .preset0     (preset0),
        .preset1     (preset1),
        .preset2     (preset2),
        .preset3     (preset3),
        .value0      (value0),
        .value1      (value1),
        .value2      (value2),
        .value3      (value3),
        .running     (running),
        .done        (done)
    );

    assign dut_val = {value3, value2, value1, value0};

    // Monitor: drains expectations on each falling edge or on an explicit async check.
    initial begin
        forever begin
            @(negedge clk or ev_check);
            while (exp_q.size() > 0) begin
                m_exp  = exp_q.pop_front();
                m_name = name_q.pop_front();
                n_cmp++;
                if ({dut_val, running, done} !== m_exp) begin
                    n_bad++;
                    $display("FAIL %s: got value=%h running=%b done=%b, expected value=%h running=%b done=%b",
                             m_name, dut_val, running, done, m_exp[17:2], m_exp[1], m_exp[0]);
                end
            end
        end
    end

    function automatic logic [15:0] to_bcd(input int n);
        to_bcd = {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    task automatic expect_now(input logic [15:0] ev, input bit er, input bit ed, input string nm);
        exp_q.push_back({ev, er, ed});
        name_q.push_back(nm);
    endtask

    task automatic set_preset(input logic [15:0] p);
        preset3 = p[15:12];
        preset2 = p[11:8];
        preset1 = p[7:4];
        preset0 = p[3:0];
    endtask

    task automatic cyc(input bit ld, input bit sp, input bit tk, input bit inc, input bit dec,
                       input logic [15:0] ev, input bit er, input bit ed, input string nm);
        @(negedge clk);
        load = ld; start_pause = sp; tick = tk; increase_en = inc; decrease_en = dec;
        @(posedge clk);
        #1;
        expect_now(ev, er, ed, nm);
    endtask

    task automatic idle_inputs();
        load = 1'b0; start_pause = 1'b0; tick = 1'b0; increase_en = 1'b0; decrease_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        set_preset(16'h0000);
        repeat (2) @(negedge clk);
        #1;
        expect_now(16'h0000, 1'b0, 1'b0, "reset_state");
        ->ev_check;
        @(negedge clk);
        rst_n = 1'b1;

        // Up-count with carry across two digits
        set_preset(16'h0998);
        cyc(1, 0, 0, 0, 0, 16'h0998, 0, 0, "load_0998");
        cyc(0, 1, 0, 1, 0, 16'h0998, 1, 0, "start_up");
        cyc(0, 0, 1, 1, 0, 16'h0999, 1, 0, "up_0999");
        cyc(0, 0, 1, 1, 0, 16'h1000, 1, 0, "up_carry_1000");
        cyc(0, 0, 1, 1, 0, 16'h1001, 1, 0, "up_1001");

        // Asynchronous reset mid-count
        set_preset(16'h0123);
        cyc(1, 0, 0, 0, 0, 16'h0123, 0, 0, "load_0123");
        cyc(0, 1, 0, 1, 0, 16'h0123, 1, 0, "start_0123");
        @(negedge clk);
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        expect_now(16'h0000, 1'b0, 1'b0, "async_reset_midcount");
        ->ev_check;
        #1 rst_n = 1'b1;
        cyc(0, 0, 1, 1, 0, 16'h0000, 0, 0, "tick_ignored_after_reset");

        // Up terminal
        set_preset(16'h9998);
        cyc(1, 0, 0, 0, 0, 16'h9998, 0, 0, "load_9998");
        cyc(0, 1, 0, 1, 0, 16'h9998, 1, 0, "start_9998");
        cyc(0, 0, 1, 1, 0, 16'h9999, 0, 1, "up_reach_limit_done");
        cyc(0, 0, 1, 1, 0, 16'h9999, 0, 1, "up_hold_limit");
        cyc(0, 1, 0, 1, 0, 16'h9999, 0, 1, "start_pause_in_done");

        // Already at limit when counting up
        set_preset(16'h9999);
        cyc(1, 0, 0, 0, 0, 16'h9999, 0, 0, "load_9999");
        cyc(0, 1, 0, 1, 0, 16'h9999, 1, 0, "start_9999");
        cyc(0, 0, 1, 1, 0, 16'h9999, 0, 1, "up_from_limit_no_wrap");

        // Down borrow and terminal
        set_preset(16'h0101);
        cyc(1, 0, 0, 0, 0, 16'h0101, 0, 0, "load_0101");
        cyc(0, 1, 0, 0, 1, 16'h0101, 1, 0, "start_down");
        for (int k = 1; k <= 101; k++) begin
            cyc(0, 0, 1, 0, 1, to_bcd(101 - k), (101 - k) != 0, (101 - k) == 0, "down_count");
        end
        cyc(0, 0, 1, 0, 1, 16'h0000, 0, 1, "down_hold_zero");

        // Priority and clamp, from DONE and from RUN
        set_preset({4'd3, 4'd12, 4'd15, 4'd4});
        cyc(1, 1, 1, 1, 0, 16'h3994, 0, 0, "load_clamp_from_done");
        cyc(0, 1, 0, 1, 0, 16'h3994, 1, 0, "start_3994");
        cyc(1, 1, 1, 1, 0, 16'h3994, 0, 0, "load_priority_from_run");

        // Pause, resume and illegal enables
        set_preset(16'h0050);
        cyc(1, 0, 0, 0, 0, 16'h0050, 0, 0, "load_0050");
        cyc(0, 1, 0, 0, 1, 16'h0050, 1, 0, "start_0050");
        cyc(0, 1, 0, 0, 1, 16'h0050, 0, 0, "pause");
        cyc(0, 0, 1, 0, 1, 16'h0050, 0, 0, "pause_tick_hold1");
        cyc(0, 0, 1, 0, 1, 16'h0050, 0, 0, "pause_tick_hold2");
        cyc(0, 1, 0, 0, 1, 16'h0050, 1, 0, "resume");
        cyc(0, 0, 1, 1, 1, 16'h0050, 1, 0, "both_enables_hold");
        cyc(0, 0, 1, 0, 0, 16'h0050, 1, 0, "no_enable_hold");
        cyc(0, 0, 1, 0, 1, 16'h0049, 1, 0, "down_0049");
        cyc(0, 1, 1, 0, 1, 16'h0049, 0, 0, "start_pause_beats_tick");

        @(negedge clk);
        idle_inputs();
        repeat (3) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
